dut_next_arbiter: RTL

DUT_NEXT_ARBITER -- requirements
Module: dut_next_arbiter

---
 rtl/dut_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/dut_next_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dut_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dut_arb_pkg
// Brief    : Shared FSM state encoding and default sizes for dut_next_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dut_arb_pkg;

    localparam int c_NREQ_DEFAULT = 4;
    localparam int c_DW_DEFAULT   = 32;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin one-hot grant; search starts after the last accepted index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_accept,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_grant_idx,
    output logic            o_any
);

    logic [IW-1:0] r_last;
    logic [IW-1:0] w_pos;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_pos       = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_pos = IW'((int'(r_last) + 1 + i) % NREQ);
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_grant_idx    = w_pos;
                o_grant[w_pos] = 1'b1;
            end
        end
    end

    // Reset value makes requester 0 the first one searched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= IW'(NREQ - 1);
        end else if (i_accept && o_any) begin
            r_last <= o_grant_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dut_next_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dut_next_arbiter
// Brief    : Shares one dut start/next interface among NREQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
module dut_next_arbiter
    import dut_arb_pkg::*;
#(
    parameter int NREQ = c_NREQ_DEFAULT,
    parameter int DW   = c_DW_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             restart,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*DW-1:0] req_k,
    output logic [NREQ-1:0]  req_ready,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [DW-1:0]    rsp_data,
    output logic             busy,
    output logic             dut_EN_start,
    input  logic             dut_RDY_start,
    output logic [DW-1:0]    dut_next_k,
    output logic             dut_EN_next,
    input  logic [DW-1:0]    dut_next,
    input  logic             dut_RDY_next
);

    localparam int c_IW = $clog2(NREQ);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [c_IW-1:0] r_idx;
    logic [DW-1:0]   r_k;
    logic [DW-1:0]   r_rsp_data;

    logic [NREQ-1:0] w_grant;
    logic [c_IW-1:0] w_grant_idx;
    logic            w_any;
    logic            w_accept;
    logic            w_en_start;
    logic            w_en_next;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk         (CLK),
        .rst         (RST),
        .i_req       (req_valid),
        .i_accept    (w_accept),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_START;
            r_idx      <= '0;
            r_k        <= '0;
            r_rsp_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_idx <= w_grant_idx;
                r_k   <= req_k[int'(w_grant_idx)*DW +: DW];
            end
            if (w_en_next) begin
                r_rsp_data <= dut_next;
            end
        end
    end

    // Restart wins over pending requests while idle.
    always_comb begin
        w_state_nxt = r_state;
        w_en_start  = 1'b0;
        w_en_next   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_START: begin
                if (dut_RDY_start) begin
                    w_en_start  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (restart) begin
                    w_state_nxt = ST_START;
                end else if (w_any) begin
                    w_accept    = !RST;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (dut_RDY_next) begin
                    w_en_next   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_START;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, independent of register state.
    assign req_ready    = w_accept ? w_grant : '0;
    assign rsp_valid    = (r_state == ST_RESP && !RST) ? (NREQ'(1) << r_idx) : '0;
    assign rsp_data     = RST ? '0 : r_rsp_data;
    assign busy         = RST || (r_state != ST_IDLE);
    assign dut_EN_start = w_en_start && !RST;
    assign dut_EN_next  = w_en_next && !RST;
    assign dut_next_k   = RST ? '0 : r_k;

endmodule
`default_nettype wire
